shift_seq: RTL and testbench
============================

# shift_seq

Multi-step shift sequencer for the shift matrix. It accepts one KL10 shift-class instruction (LSH, ASH, ROT, LSHC, ASHC, ROTC) with its effective-address count. It reduces rotate counts modulo word length, then issues a series of shift-matrix steps of at most 35 bits each, selecting AR, ARX or the AR/ARX pair. It sits between EBOX microcode dispatch and the shift matrix and drives its select code, its step amount and the AR/ARX load strobes.

## Interface
Parameters:
- `MAXSTEP`, 35: largest shift amount issued in one step (1..35).

Ports:
- `eboxClk` in 1: EBOX clock; all state changes on the rising edge.
- `eboxReset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `op` in 3: 0 LSH, 1 ROT, 2 ASH, 3 LSHC, 4 ROTC, 5 ASHC; 6–7 illegal.
- `count` in [0:17]: E right half. `count[0]` is the sign (1 = right shift). `count[10:17]` is the magnitude m (0..255).
- `abort` in 1: page fail / interrupt; abandons the operation.
- `busy` out 1: high from the cycle after an accepted start through the DONE cycle.
- `stepValid` out 1: one shift-matrix step is presented this cycle.
- `shSel` out 2: matrix source select. 0 = AR‖ARX (combined ops), 1 = AR only (single ops).
- `shAmt` out 6: step amount, 0..MAXSTEP.
- `shRight` out 1: step direction.
- `shRotate` out 1: end-around fill.
- `shFillSign` out 1: fill with AR bit 0 (ASH/ASHC right); otherwise fill zero.
- `shClear` out 1: fill step; destination becomes all fill.
- `loadAR`, `loadARX` out 1: destination strobes, valid with `stepValid`.
- `done` out 1: one-cycle completion pulse.
- `illegal` out 1: one-cycle pulse when `op` is 6 or 7; no steps are issued.

## Operation
- States: IDLE, SETUP, REDUCE, STEP, DONE.
- **IDLE**
  - `start` with a legal op: latch op, sign and m, go to SETUP.
  - `start` with an illegal op: pulse `illegal`, stay in IDLE.
- **SETUP**
  - Word length L = 36 for single ops, 72 for combined ops.
  - Rotate with m ≥ L: go to REDUCE.
  - Non-rotate with m ≥ L: issue exactly one `shClear` step, then DONE.
  - m = 0: go to DONE with no steps.
  - Otherwise go to STEP.
- **REDUCE**
  - Each cycle: m ← m − L while m ≥ L.
  - Then go to STEP, or to DONE if m = 0.
  - Takes floor(m/L) cycles.
- **STEP**
  - `shAmt` = min(remaining, MAXSTEP); remaining ← remaining − shAmt.
  - Go to DONE when remaining becomes 0.
  - Single ops assert `loadAR` only. Combined ops assert both strobes.
  - `shRotate` is set for ROT/ROTC. `shFillSign` is set for ASH/ASHC with right shift.
- **DONE**: pulse `done`, return to IDLE.
- `start` while `busy` is ignored.
- `abort` in any non-IDLE state: IDLE next cycle. No `done`, no further steps; strobes drop the same cycle (combinationally gated).
- Arithmetic:
  - Remaining count is 8-bit unsigned.
  - The subtract in REDUCE never underflows (guarded by a compare).
  - `shAmt` is zero-extended from the low 6 bits.

## Timing
- Reset values: all outputs 0, state IDLE, internal count 0.
- Reset mid-operation clears everything asynchronously; no `done` is produced.
- Latency from start to done, with N steps and R reduce cycles: 1 (SETUP) + R + N + 1. The m = 0 case takes 2 cycles.
- `stepValid` is high exactly N cycles, and these cycles are consecutive.
- The matrix and registers load on the same edge that advances the step.
- `abort` coinciding with the last step: the step strobes are suppressed and `done` is not issued.

## Structure
- Shared package `kl_shift_pkg`:
  - op encoding enum;
  - state enum;
  - constants WORD_LEN_SINGLE = 36 and WORD_LEN_COMBINED = 72;
  - shSel codes.
- The shift matrix module will import the same shSel codes.
- One natural sub-module, `shift_count_reduce`: the compare/subtract modulo datapath with its own remaining-count register. The FSM stays in `shift_seq`.

## Test plan
- LSHC, count 50 left → two steps, shAmt 35 then 15, shRight 0, both loads each step, done at cycle 4 after start.
- ROTC, count 100 → REDUCE 1 cycle (100 → 28), then one step shAmt 28 with shRotate 1, done at cycle 4.
- ASH, count[0] = 1, m = 40 → one shClear step with shFillSign 1 and loadAR only, then done.
- ROT, m = 72 → REDUCE 2 cycles to 0, no steps, done at cycle 4. Also m = 0 LSH → done at cycle 2.
- ROTC, m = 71 → steps 35, 35, 1. Assert abort during the second step → strobes low that cycle, IDLE next, no done.
- op = 7 → illegal pulse, busy stays 0. Assert eboxReset mid-LSHC → all outputs 0 immediately, and a fresh start then runs normally.

Source files
------------

// File: rtl/kl_shift_pkg.sv
// Shared definitions for the KL10 shift-class sequencer and the shift matrix.
package kl_shift_pkg;

  typedef enum logic [2:0] {
    OP_LSH  = 3'd0,
    OP_ROT  = 3'd1,
    OP_ASH  = 3'd2,
    OP_LSHC = 3'd3,
    OP_ROTC = 3'd4,
    OP_ASHC = 3'd5
  } shift_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_REDUCE,
    ST_STEP,
    ST_DONE
  } seq_state_e;

  localparam logic [7:0] WORD_LEN_SINGLE   = 8'd36;
  localparam logic [7:0] WORD_LEN_COMBINED = 8'd72;

  // Shift matrix source select codes.
  localparam logic [1:0] SH_SEL_PAIR = 2'd0;
  localparam logic [1:0] SH_SEL_AR   = 2'd1;

  function automatic logic op_is_legal(input logic [2:0] code);
    return code <= 3'd5;
  endfunction

  function automatic logic op_is_combined(input shift_op_e o);
    return (o == OP_LSHC) || (o == OP_ROTC) || (o == OP_ASHC);
  endfunction

  function automatic logic op_is_rotate(input shift_op_e o);
    return (o == OP_ROT) || (o == OP_ROTC);
  endfunction

  function automatic logic op_is_arith(input shift_op_e o);
    return (o == OP_ASH) || (o == OP_ASHC);
  endfunction

  function automatic logic [7:0] word_len_of(input shift_op_e o);
    return op_is_combined(o) ? WORD_LEN_COMBINED : WORD_LEN_SINGLE;
  endfunction

endpackage

// File: rtl/shift_count_reduce.sv
// Remaining-count register with modulo reduce and per-step subtract.
// rem_nxt is exposed so the sequencer can size the next step on the same edge.
module shift_count_reduce
  import kl_shift_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       clear,
  input  logic       reduce,
  input  logic       step,
  input  logic [7:0] word_len,
  input  logic [5:0] step_amt,
  output logic [7:0] rem,
  output logic [7:0] rem_nxt,
  output logic       rem_ge_len,
  output logic       nxt_ge_len
);

  logic [7:0] step_ext;

  assign step_ext   = {2'b00, step_amt};
  assign rem_ge_len = (rem >= word_len);
  assign nxt_ge_len = (rem_nxt >= word_len);

  // Next count: clear wins, then load, then a guarded subtract.
  always_comb begin
    rem_nxt = rem;
    if (clear) begin
      rem_nxt = '0;
    end else if (load) begin
      rem_nxt = load_val;
    end else if (reduce && rem_ge_len) begin
      rem_nxt = rem - word_len;
    end else if (step && (rem >= step_ext)) begin
      rem_nxt = rem - step_ext;
    end
  end

  // Remaining-count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0;
    end else begin
      rem <= rem_nxt;
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-step shift sequencer: splits one shift-class instruction into
// shift-matrix steps of at most MAXSTEP bits.
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | waiting for start
// ST_SETUP  | count latched, classify (reduce / clear / none / step)
// ST_REDUCE | rotate count being reduced modulo word length
// ST_STEP   | one shift-matrix step presented per cycle
// ST_DONE   | completion pulse, back to idle
module shift_seq
  import kl_shift_pkg::*;
#(
  parameter int MAXSTEP = 35
) (
  input  logic        eboxClk,
  input  logic        eboxReset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [0:17] count,
  input  logic        abort,
  output logic        busy,
  output logic        stepValid,
  output logic [1:0]  shSel,
  output logic [5:0]  shAmt,
  output logic        shRight,
  output logic        shRotate,
  output logic        shFillSign,
  output logic        shClear,
  output logic        loadAR,
  output logic        loadARX,
  output logic        done,
  output logic        illegal
);

  localparam logic [7:0] MAX_STEP = 8'(MAXSTEP);

  seq_state_e state;
  shift_op_e  op_q;
  logic       right_q;

  logic [7:0] rem, rem_nxt, word_len, amt_src;
  logic       rem_ge_len, nxt_ge_len;
  logic       cnt_load, cnt_clear, cnt_reduce, cnt_step;
  logic       issue, issue_clear, finish;
  logic [5:0] next_amt;

  logic       step_valid_q, load_ar_q, load_arx_q, done_q, illegal_q;
  logic       sh_right_q, sh_rotate_q, sh_fill_sign_q, sh_clear_q;
  logic [1:0] sh_sel_q;
  logic [5:0] sh_amt_q;

  // Count bits 1..9 of E are not part of the shift amount.
  logic       unused_count_bits;
  assign unused_count_bits = ^count[1:9];

  assign word_len = word_len_of(op_q);

  // Counter commands; a non-rotate overshift empties the count at once.
  always_comb begin
    cnt_load   = (state == ST_IDLE) && start && op_is_legal(op);
    cnt_clear  = (state != ST_IDLE) &&
                 (abort || ((state == ST_SETUP) && rem_ge_len && !op_is_rotate(op_q)));
    cnt_reduce = (state == ST_REDUCE) && !abort;
    cnt_step   = (state == ST_STEP) && !abort;
  end

  shift_count_reduce u_count (
    .clk        (eboxClk),
    .rst        (eboxReset),
    .load       (cnt_load),
    .load_val   (count[10:17]),
    .clear      (cnt_clear),
    .reduce     (cnt_reduce),
    .step       (cnt_step),
    .word_len   (word_len),
    .step_amt   (sh_amt_q),
    .rem        (rem),
    .rem_nxt    (rem_nxt),
    .rem_ge_len (rem_ge_len),
    .nxt_ge_len (nxt_ge_len)
  );

  // Decide whether the coming cycle carries a step or the done pulse.
  always_comb begin
    issue       = 1'b0;
    issue_clear = 1'b0;
    finish      = 1'b0;
    amt_src     = (state == ST_SETUP) ? rem : rem_nxt;
    next_amt    = (amt_src > MAX_STEP) ? MAX_STEP[5:0] : amt_src[5:0];
    if (!abort) begin
      case (state)
        ST_SETUP: begin
          if (rem_ge_len) begin
            if (!op_is_rotate(op_q)) begin
              issue       = 1'b1;
              issue_clear = 1'b1;
            end
          end else if (rem == 8'd0) begin
            finish = 1'b1;
          end else begin
            issue = 1'b1;
          end
        end
        ST_REDUCE: begin
          if (!nxt_ge_len) begin
            if (rem_nxt == 8'd0) finish = 1'b1;
            else                 issue  = 1'b1;
          end
        end
        ST_STEP: begin
          if (rem_nxt == 8'd0) finish = 1'b1;
          else                 issue  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sequencer state and registered step outputs.
  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) begin
      state          <= ST_IDLE;
      op_q           <= OP_LSH;
      right_q        <= 1'b0;
      step_valid_q   <= 1'b0;
      load_ar_q      <= 1'b0;
      load_arx_q     <= 1'b0;
      done_q         <= 1'b0;
      illegal_q      <= 1'b0;
      sh_sel_q       <= SH_SEL_PAIR;
      sh_amt_q       <= '0;
      sh_right_q     <= 1'b0;
      sh_rotate_q    <= 1'b0;
      sh_fill_sign_q <= 1'b0;
      sh_clear_q     <= 1'b0;
    end else begin
      step_valid_q   <= 1'b0;
      load_ar_q      <= 1'b0;
      load_arx_q     <= 1'b0;
      done_q         <= 1'b0;
      illegal_q      <= 1'b0;
      sh_sel_q       <= SH_SEL_PAIR;
      sh_amt_q       <= '0;
      sh_right_q     <= 1'b0;
      sh_rotate_q    <= 1'b0;
      sh_fill_sign_q <= 1'b0;
      sh_clear_q     <= 1'b0;

      if (abort && (state != ST_IDLE)) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (op_is_legal(op)) begin
                op_q    <= shift_op_e'(op);
                right_q <= count[0];
                state   <= ST_SETUP;
              end else begin
                illegal_q <= 1'b1;
              end
            end
          end
          ST_SETUP:  state <= issue ? ST_STEP : (finish ? ST_DONE : ST_REDUCE);
          ST_REDUCE: state <= issue ? ST_STEP : (finish ? ST_DONE : ST_REDUCE);
          ST_STEP:   state <= finish ? ST_DONE : ST_STEP;
          default:   state <= ST_IDLE;
        endcase

        if (issue) begin
          step_valid_q   <= 1'b1;
          load_ar_q      <= 1'b1;
          load_arx_q     <= op_is_combined(op_q);
          sh_sel_q       <= op_is_combined(op_q) ? SH_SEL_PAIR : SH_SEL_AR;
          sh_amt_q       <= issue_clear ? 6'd0 : next_amt;
          sh_right_q     <= right_q;
          sh_rotate_q    <= op_is_rotate(op_q);
          sh_fill_sign_q <= op_is_arith(op_q) && right_q;
          sh_clear_q     <= issue_clear;
        end
        if (finish) begin
          done_q <= 1'b1;
        end
      end
    end
  end

  // Abort kills the strobes in the cycle it arrives.
  assign busy       = (state != ST_IDLE);
  assign stepValid  = step_valid_q & ~abort;
  assign loadAR     = load_ar_q & ~abort;
  assign loadARX    = load_arx_q & ~abort;
  assign done       = done_q & ~abort;
  assign illegal    = illegal_q;
  assign shSel      = sh_sel_q;
  assign shAmt      = sh_amt_q;
  assign shRight    = sh_right_q;
  assign shRotate   = sh_rotate_q;
  assign shFillSign = sh_fill_sign_q;
  assign shClear    = sh_clear_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: table of whole operations plus corner sequences.
module tb_shift_seq;

  logic        eboxClk;
  logic        eboxReset;
  logic        start;
  logic [2:0]  op;
  logic [0:17] count;
  logic        abort;
  logic        busy, stepValid, shRight, shRotate, shFillSign, shClear;
  logic        loadAR, loadARX, done, illegal;
  logic [1:0]  shSel;
  logic [5:0]  shAmt;

  int checks = 0;
  int errors = 0;

  shift_seq #(.MAXSTEP(35)) dut (
    .eboxClk    (eboxClk),
    .eboxReset  (eboxReset),
    .start      (start),
    .op         (op),
    .count      (count),
    .abort      (abort),
    .busy       (busy),
    .stepValid  (stepValid),
    .shSel      (shSel),
    .shAmt      (shAmt),
    .shRight    (shRight),
    .shRotate   (shRotate),
    .shFillSign (shFillSign),
    .shClear    (shClear),
    .loadAR     (loadAR),
    .loadARX    (loadARX),
    .done       (done),
    .illegal    (illegal)
  );

  initial eboxClk = 1'b0;
  always #5 eboxClk = ~eboxClk;

  typedef struct {
    logic [2:0] op;
    logic       sgn;
    logic [7:0] m;
    int         nsteps;
    logic [5:0] a0, a1, a2;
    int         lat;
    logic       sel;
    logic       arx;
    logic       rot;
    logic       fill;
    logic       clr;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] all_outs();
    return {busy, stepValid, shSel, shAmt, shRight, shRotate, shFillSign,
            shClear, loadAR, loadARX, done, illegal};
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, n_seen, done_cyc, first_cyc, last_cyc;
    logic [5:0] exp_amt;
    @(negedge eboxClk);
    start = 1'b1;
    op    = v.op;
    count = {v.sgn, 9'd0, v.m};
    @(negedge eboxClk);
    start = 1'b0;
    cyc = 1; n_seen = 0; done_cyc = -1; first_cyc = -1; last_cyc = -1;
    chk($sformatf("v%0d busy_c1", idx), busy, 1);
    while (cyc <= 20 && done_cyc < 0) begin
      if (stepValid) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        case (n_seen)
          0:       exp_amt = v.a0;
          1:       exp_amt = v.a1;
          default: exp_amt = v.a2;
        endcase
        if (!v.clr) chk($sformatf("v%0d amt%0d", idx, n_seen), shAmt, exp_amt);
        chk($sformatf("v%0d sel%0d", idx, n_seen), shSel, {1'b0, v.sel});
        chk($sformatf("v%0d loads%0d", idx, n_seen), {loadAR, loadARX}, {1'b1, v.arx});
        chk($sformatf("v%0d flags%0d", idx, n_seen),
            {shRight, shRotate, shFillSign, shClear}, {v.sgn, v.rot, v.fill, v.clr});
        n_seen++;
      end
      if (done) done_cyc = cyc;
      @(negedge eboxClk);
      cyc++;
    end
    chk($sformatf("v%0d latency", idx), done_cyc, v.lat);
    chk($sformatf("v%0d nsteps", idx), n_seen, v.nsteps);
    if (n_seen > 0) begin
      chk($sformatf("v%0d last_step", idx), last_cyc, v.lat - 1);
      chk($sformatf("v%0d step_span", idx), last_cyc - first_cyc + 1, n_seen);
    end
    chk($sformatf("v%0d idle_after", idx), {busy, done, stepValid}, 3'b000);
  endtask

  initial begin
    int done_cyc, step_cnt;
    logic seen;

    //          op    sgn   m       n  a0     a1     a2     lat sel  arx  rot  fill clr
    vecs[0]  = '{3'd3, 1'b0, 8'd50,  2, 6'd35, 6'd15, 6'd0, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'd4, 1'b0, 8'd100, 1, 6'd28, 6'd0,  6'd0, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3'd2, 1'b1, 8'd40,  1, 6'd0,  6'd0,  6'd0, 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{3'd1, 1'b0, 8'd72,  0, 6'd0,  6'd0,  6'd0, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'd0, 1'b0, 8'd0,   0, 6'd0,  6'd0,  6'd0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd4, 1'b0, 8'd71,  3, 6'd35, 6'd35, 6'd1, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{3'd0, 1'b1, 8'd36,  1, 6'd0,  6'd0,  6'd0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{3'd5, 1'b1, 8'd71,  3, 6'd35, 6'd35, 6'd1, 5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{3'd2, 1'b0, 8'd35,  1, 6'd35, 6'd0,  6'd0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd1, 1'b1, 8'd37,  1, 6'd1,  6'd0,  6'd0, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'd5, 1'b0, 8'd72,  1, 6'd0,  6'd0,  6'd0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{3'd0, 1'b0, 8'd255, 1, 6'd0,  6'd0,  6'd0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{3'd1, 1'b0, 8'd36,  0, 6'd0,  6'd0,  6'd0, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{3'd2, 1'b1, 8'd34,  1, 6'd34, 6'd0,  6'd0, 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{3'd4, 1'b1, 8'd255, 2, 6'd35, 6'd4,  6'd0, 7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    eboxReset = 1'b1;
    start = 1'b0;
    op = 3'd0;
    count = '0;
    abort = 1'b0;
    #2;
    chk("reset_outs", all_outs(), 17'd0);
    repeat (2) @(negedge eboxClk);
    eboxReset = 1'b0;
    @(negedge eboxClk);
    chk("idle_outs", all_outs(), 17'd0);

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Illegal op: one-cycle pulse, never busy.
    @(negedge eboxClk);
    start = 1'b1; op = 3'd7; count = {1'b0, 9'd0, 8'd10};
    @(negedge eboxClk);
    start = 1'b0;
    chk("illegal_pulse", {illegal, busy, stepValid}, 3'b100);
    @(negedge eboxClk);
    chk("illegal_end", {illegal, busy, stepValid}, 3'b000);

    // Abort in the second step of ROTC 71.
    @(negedge eboxClk);
    start = 1'b1; op = 3'd4; count = {1'b0, 9'd0, 8'd71};
    @(negedge eboxClk);
    start = 1'b0;
    repeat (2) @(negedge eboxClk);
    chk("abort_pre_step", {stepValid, shAmt}, {1'b1, 6'd35});
    abort = 1'b1;
    #1;
    chk("abort_strobes", {stepValid, loadAR, loadARX, done}, 4'b0000);
    @(negedge eboxClk);
    abort = 1'b0;
    chk("abort_idle", {busy, stepValid}, 2'b00);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | done | stepValid;
      @(negedge eboxClk);
    end
    chk("abort_no_done", seen, 1'b0);

    // Start while busy is ignored.
    start = 1'b1; op = 3'd4; count = {1'b0, 9'd0, 8'd71};
    @(negedge eboxClk);
    start = 1'b0;
    done_cyc = -1; step_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin
        start = 1'b1; op = 3'd0; count = '0;
      end else begin
        start = 1'b0;
      end
      if (stepValid) step_cnt++;
      if (done && done_cyc < 0) done_cyc = c;
      @(negedge eboxClk);
    end
    start = 1'b0;
    chk("busy_start_latency", done_cyc, 5);
    chk("busy_start_steps", step_cnt, 3);

    // Reset mid-LSHC, then a fresh operation.
    start = 1'b1; op = 3'd3; count = {1'b0, 9'd0, 8'd50};
    @(negedge eboxClk);
    start = 1'b0;
    @(negedge eboxClk);
    chk("rst_pre_step", stepValid, 1'b1);
    eboxReset = 1'b1;
    #1;
    chk("rst_mid_outs", all_outs(), 17'd0);
    @(negedge eboxClk);
    eboxReset = 1'b0;
    chk("rst_after_outs", all_outs(), 17'd0);
    run_vec(99, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
